cnn_layer_accel_ce_macc_ctrl: RTL and testbench

Sequencer that drives one DSP48E2 MACC slice in the CE (A/B/C data, OPMODE, ALUMODE, CE, rst) and collects its P output. It accepts one accumulation job: a bias plus N operand pairs. It streams the pairs into the slice with correctly delayed opmodes, drains the 4-stage slice pipeline, and returns the final sum on a valid/ready result port. The MACC slice is configured as AREG=BREG=2, MREG=1, PREG=1, CREG=1, OPMODEREG=1, ALUMODEREG=1.

---
 rtl/cnn_layer_accel_ce_macc_ctrl.sv | 146 ++++++++++++++
 tb/tb_cnn_layer_accel_ce_macc_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_layer_accel_ce_macc_ctrl.sv
// Sequencer for one DSP48E2 MACC slice in the CE.
// It accepts a job made of a bias and N operand pairs. The pairs stream into the slice.
// The OPMODE for each pair lags it by the slice's A/B register depth.
// After the last pair the 4-stage pipeline is drained and the final P is returned
// on a valid/ready result port.
module cnn_layer_accel_ce_macc_ctrl #(
    parameter int C_A_INPUT_WIDTH  = 30,
    parameter int C_B_INPUT_WIDTH  = 18,
    parameter int C_C_INPUT_WIDTH  = 48,
    parameter int C_P_OUTPUT_WIDTH = 48,
    parameter int C_KLEN_WIDTH     = 16,
    parameter int C_OPMODE_DELAY   = 2,
    parameter int C_MACC_LATENCY   = 4
) (
    input  logic                        CLK,
    input  logic                        rst,
    input  logic                        start,
    input  logic [C_KLEN_WIDTH-1:0]     cfg_kernel_len,
    input  logic [C_C_INPUT_WIDTH-1:0]  cfg_bias,
    output logic                        busy,
    input  logic                        op_valid,
    output logic                        op_ready,
    input  logic [C_A_INPUT_WIDTH-1:0]  op_a,
    input  logic [C_B_INPUT_WIDTH-1:0]  op_b,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic [C_P_OUTPUT_WIDTH-1:0] res_data,
    output logic                        macc_rst,
    output logic                        macc_ce,
    output logic [8:0]                  macc_opmode,
    output logic [3:0]                  macc_alumode,
    output logic [C_A_INPUT_WIDTH-1:0]  macc_a,
    output logic [C_B_INPUT_WIDTH-1:0]  macc_b,
    output logic [C_C_INPUT_WIDTH-1:0]  macc_c,
    input  logic [C_P_OUTPUT_WIDTH-1:0] macc_p
);

    // W,Z,Y,X opmode encodings: C+A*B, P+A*B, and hold P.
    localparam logic [8:0] OPMODE_FIRST = 9'b000110101;
    localparam logic [8:0] OPMODE_ACC   = 9'b000100101;
    localparam logic [8:0] OPMODE_HOLD  = 9'b000100000;

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, RESULT} state_t;

    state_t                        state_q;
    logic [C_KLEN_WIDTH-1:0]       kLen_q;
    logic [C_KLEN_WIDTH-1:0]       opCnt_q;
    logic [C_C_INPUT_WIDTH-1:0]    bias_q;
    logic [C_P_OUTPUT_WIDTH-1:0]   resData_q;

    // The token pipe mirrors the slice pipeline one stage per CE cycle.
    // The first flag is only consulted at the opmode stage, so it stops there.
    logic [C_MACC_LATENCY:1]       tokValid_q, tokValid_d;
    logic [C_MACC_LATENCY:1]       tokLast_q,  tokLast_d;
    logic [C_OPMODE_DELAY:1]       tokFirst_q, tokFirst_d;

    logic opHs;
    logic lastOp;

    assign opHs   = (state_q == ACCUM) && op_valid;
    assign lastOp = (opCnt_q == (kLen_q - C_KLEN_WIDTH'(1)));

    assign tokValid_d = {tokValid_q[C_MACC_LATENCY-1:1], opHs};
    assign tokLast_d  = {tokLast_q[C_MACC_LATENCY-1:1], opHs && lastOp};
    assign tokFirst_d = {tokFirst_q[C_OPMODE_DELAY-1:1], opHs && (opCnt_q == '0)};

    // Slice-facing controls: a bubble in ACCUM freezes the whole slice, and DRAIN always clocks it.
    always_comb begin
        busy         = (state_q != IDLE);
        op_ready     = (state_q == ACCUM);
        res_valid    = (state_q == RESULT);
        res_data     = resData_q;
        macc_rst     = rst;
        macc_ce      = opHs || (state_q == DRAIN);
        macc_alumode = 4'b0000;
        macc_a       = opHs ? op_a : '0;
        macc_b       = opHs ? op_b : '0;
        macc_c       = bias_q;
        macc_opmode  = OPMODE_HOLD;
        if (tokValid_q[C_OPMODE_DELAY]) begin
            macc_opmode = tokFirst_q[C_OPMODE_DELAY] ? OPMODE_FIRST : OPMODE_ACC;
        end
    end

    // Advance the token pipe in lockstep with the slice clock enable.
    always_ff @(posedge CLK) begin
        if (rst) begin
            tokValid_q <= '0;
            tokLast_q  <= '0;
            tokFirst_q <= '0;
        end else if (macc_ce) begin
            tokValid_q <= tokValid_d;
            tokLast_q  <= tokLast_d;
            tokFirst_q <= tokFirst_d;
        end
    end

    // Job FSM: latch the config, count operands, wait for the last token, then hold the result.
    always_ff @(posedge CLK) begin
        if (rst) begin
            state_q   <= IDLE;
            kLen_q    <= '0;
            opCnt_q   <= '0;
            bias_q    <= '0;
            resData_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        kLen_q  <= cfg_kernel_len;
                        bias_q  <= cfg_bias;
                        opCnt_q <= '0;
                        if (cfg_kernel_len == '0) begin
                            resData_q <= C_P_OUTPUT_WIDTH'($signed(cfg_bias));
                            state_q   <= RESULT;
                        end else begin
                            state_q   <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (op_valid) begin
                        if (lastOp) begin
                            state_q <= DRAIN;
                        end else begin
                            opCnt_q <= opCnt_q + C_KLEN_WIDTH'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (tokValid_q[C_MACC_LATENCY] && tokLast_q[C_MACC_LATENCY]) begin
                        resData_q <= macc_p;
                        state_q   <= RESULT;
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_layer_accel_ce_macc_ctrl.sv
// Testbench for cnn_layer_accel_ce_macc_ctrl.
// A behavioural DSP48E2 slice is attached (AREG=BREG=2, MREG/PREG/CREG/OPMODEREG=1).
// Each job's expected sum, bias + sum(a*b) mod 2^48, is queued when the job is issued.
// A monitor process compares queued sums against the result port.
module tb_cnn_layer_accel_ce_macc_ctrl;

    localparam int AW = 30;
    localparam int BW = 18;
    localparam int CW = 48;
    localparam int PW = 48;
    localparam int KW = 16;
    localparam logic [8:0] OPM_FIRST = 9'b000110101;
    localparam logic [8:0] OPM_ACC   = 9'b000100101;
    localparam logic [8:0] OPM_HOLD  = 9'b000100000;

    logic          CLK = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] cfg_kernel_len;
    logic [CW-1:0] cfg_bias;
    logic          busy;
    logic          op_valid;
    logic          op_ready;
    logic [AW-1:0] op_a;
    logic [BW-1:0] op_b;
    logic          res_valid;
    logic          res_ready;
    logic [PW-1:0] res_data;
    logic          macc_rst;
    logic          macc_ce;
    logic [8:0]    macc_opmode;
    logic [3:0]    macc_alumode;
    logic [AW-1:0] macc_a;
    logic [BW-1:0] macc_b;
    logic [CW-1:0] macc_c;
    logic [PW-1:0] macc_p;

    always #5 CLK = ~CLK;

    cnn_layer_accel_ce_macc_ctrl dut (
        .CLK(CLK), .rst(rst), .start(start), .cfg_kernel_len(cfg_kernel_len), .cfg_bias(cfg_bias),
        .busy(busy), .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .macc_rst(macc_rst), .macc_ce(macc_ce), .macc_opmode(macc_opmode),
        .macc_alumode(macc_alumode), .macc_a(macc_a), .macc_b(macc_b), .macc_c(macc_c),
        .macc_p(macc_p)
    );

    // Behavioural MACC slice: two A/B register stages, then M, then P, all qualified by CE.
    logic signed [AW-1:0] sa1, sa2;
    logic signed [BW-1:0] sb1, sb2;
    logic [PW-1:0] sm, sp, sc;
    logic [8:0]    sopm;
    assign macc_p = sp;

    function automatic logic [PW-1:0] postAdder(input logic [8:0] opm, input logic [PW-1:0] m,
                                                input logic [PW-1:0] c, input logic [PW-1:0] p);
        logic [PW-1:0] xy;
        logic [PW-1:0] z;
        xy = (opm[3:0] == 4'b0101) ? m : '0;
        case (opm[6:4])
            3'b010:  z = p;
            3'b011:  z = c;
            default: z = '0;
        endcase
        return z + xy;
    endfunction

    always @(posedge CLK) begin
        if (macc_rst) begin
            sa1 <= '0; sa2 <= '0; sb1 <= '0; sb2 <= '0;
            sm <= '0; sp <= '0; sc <= '0; sopm <= '0;
        end else if (macc_ce) begin
            sa1  <= macc_a;
            sa2  <= sa1;
            sb1  <= macc_b;
            sb2  <= sb1;
            sm   <= PW'(longint'(sa2) * longint'(sb2));
            sc   <= macc_c;
            sopm <= macc_opmode;
            sp   <= postAdder(sopm, sm, sc, sp);
        end
    end

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] expQ[$];
    logic [8:0]    opLog[$];
    int            hsIdx[$];
    int            ceCount;
    int            refCycle;
    int            expLatency;
    logic [CW-1:0] curBias;
    logic [AW-1:0] jobA[$];
    logic [BW-1:0] jobB[$];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: logs the slice-side activity and scores every accepted result against the queue.
    task automatic monitorLoop();
        logic          prevBusy = 1'b0;
        logic          prevCe = 1'b0;
        logic          prevRst = 1'b1;
        logic          prevResValid = 1'b0;
        logic [8:0]    prevOpmode = OPM_HOLD;
        logic [PW-1:0] expVal;
        forever begin
            @(negedge CLK);
            if (!rst) begin
                if (macc_ce) begin
                    ceCount++;
                    opLog.push_back(macc_opmode);
                    checkOutput("macc_c_held", 64'(macc_c), 64'(curBias));
                    checkOutput("macc_alumode", 64'(macc_alumode), 64'd0);
                end
                if (op_valid && op_ready) hsIdx.push_back(opLog.size() - 1);
                if (busy && prevBusy && !prevCe && !prevRst)
                    checkOutput("opmode_frozen", 64'(macc_opmode), 64'(prevOpmode));
                if (res_valid && !prevResValid && expLatency > 0)
                    checkOutput("res_valid_latency", 64'(cyc - refCycle), 64'(expLatency));
                if (res_valid && res_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_result", 64'd1, 64'd0);
                    end else begin
                        expVal = expQ.pop_front();
                        checkOutput("res_data", 64'(res_data), 64'(expVal));
                    end
                end
            end
            prevBusy     = busy;
            prevCe       = macc_ce;
            prevRst      = rst;
            prevResValid = res_valid;
            prevOpmode   = macc_opmode;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        checkOutput({tag, "_op_ready"}, 64'(op_ready), 64'd0);
        checkOutput({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        checkOutput({tag, "_macc_ce"}, 64'(macc_ce), 64'd0);
        checkOutput({tag, "_res_data"}, 64'(res_data), 64'd0);
        checkOutput({tag, "_macc_ab"}, 64'({macc_a, macc_b}), 64'd0);
        checkOutput({tag, "_macc_c"}, 64'(macc_c), 64'd0);
        checkOutput({tag, "_opmode"}, 64'(macc_opmode), 64'(OPM_HOLD));
        checkOutput({tag, "_macc_rst"}, 64'(macc_rst), 64'd0);
    endtask

    task automatic addPair(input int a, input int b);
        jobA.push_back(AW'(a));
        jobB.push_back(BW'(b));
    endtask

    // Issue one job from jobA/jobB. gapMode 1 inserts random bubbles; gapMode 2 inserts 3 bubbles before pair 2.
    task automatic applyStimulus(input int n, input logic [CW-1:0] bias, input int gapMode,
                                 input int readyDelay, input bit holdTest, input bit abortJob);
        logic [PW-1:0] acc;
        logic [PW-1:0] heldData;
        int nonHold;
        int gap;
        int tries;
        bit hs;
        bit sawValid;

        acc = PW'(bias);
        for (int i = 0; i < n; i++)
            acc += PW'(longint'($signed(jobA[i])) * longint'($signed(jobB[i])));
        if (!abortJob) expQ.push_back(acc);

        tries = 0;
        while (busy && tries < 50) begin @(negedge CLK); tries++; end
        @(posedge CLK); #1;
        opLog.delete();
        hsIdx.delete();
        ceCount    = 0;
        curBias    = bias;
        expLatency = (n == 0) ? 1 : 0;
        start = 1'b1; cfg_kernel_len = KW'(n); cfg_bias = bias;
        @(negedge CLK);
        refCycle = cyc;
        @(posedge CLK); #1;
        start = 1'b0; cfg_kernel_len = KW'($urandom); cfg_bias = CW'({$urandom, $urandom});

        for (int i = 0; i < n; i++) begin
            gap = (gapMode == 1) ? $urandom_range(0, 2) : ((gapMode == 2 && i == 2) ? 3 : 0);
            for (int g = 0; g < gap; g++) begin
                op_valid = 1'b0; op_a = AW'($urandom); op_b = BW'($urandom);
                @(negedge CLK);
                if (gapMode == 2) checkOutput("ce_in_gap", 64'(macc_ce), 64'd0);
                @(posedge CLK); #1;
            end
            op_valid = 1'b1; op_a = jobA[i]; op_b = jobB[i];
            hs = 1'b0;
            tries = 0;
            while (!hs && tries < 20) begin
                @(negedge CLK);
                hs = op_ready;
                if (hs && i == n - 1) refCycle = cyc;
                @(posedge CLK); #1;
                tries++;
            end
            if (!hs) checkOutput("op_ready_timeout", 64'd0, 64'd1);
        end
        op_valid = 1'b0;
        if (n > 0) expLatency = 5;

        if (abortJob) begin
            expLatency = 0;
            rst = 1'b1;
            @(negedge CLK);
            checkOutput("macc_rst_follows", 64'(macc_rst), 64'd1);
            @(posedge CLK); #1;
            rst = 1'b0;
            @(negedge CLK);
            checkResetOutputs("abort");
            sawValid = 1'b0;
            for (int k = 0; k < 8; k++) begin
                @(negedge CLK);
                if (res_valid) sawValid = 1'b1;
            end
            checkOutput("abort_no_result", 64'(sawValid), 64'd0);
            return;
        end

        tries = 0;
        while (!res_valid && tries < 60) begin @(negedge CLK); tries++; end
        if (!res_valid) begin
            checkOutput("res_valid_timeout", 64'd0, 64'd1);
            expQ.delete();
            return;
        end
        heldData = res_data;
        for (int h = 0; h < readyDelay; h++) begin
            if (holdTest) begin
                checkOutput("hold_res_data", 64'(res_data), 64'(heldData));
                checkOutput("hold_busy", 64'(busy), 64'd1);
                checkOutput("hold_res_valid", 64'(res_valid), 64'd1);
            end
            @(posedge CLK); #1;
            start = holdTest && (h == 4);
            cfg_kernel_len = KW'(2);
            @(negedge CLK);
        end
        @(posedge CLK); #1;
        res_ready = 1'b1;
        start = holdTest;
        @(posedge CLK); #1;
        res_ready = 1'b0;
        start = 1'b0;
        @(negedge CLK);
        checkOutput("idle_after_ready", 64'(busy), 64'd0);
        checkOutput("res_valid_drop", 64'(res_valid), 64'd0);

        if (n == 0) begin
            checkOutput("ce_unused_n0", 64'(ceCount), 64'd0);
        end else begin
            checkOutput("handshake_count", 64'(hsIdx.size()), 64'(n));
            nonHold = 0;
            foreach (opLog[k]) if (opLog[k] != OPM_HOLD) nonHold++;
            checkOutput("opmode_count", 64'(nonHold), 64'(n));
            for (int i = 0; i < n && i < hsIdx.size(); i++) begin
                if (hsIdx[i] + 2 < opLog.size())
                    checkOutput("opmode_seq", 64'(opLog[hsIdx[i] + 2]), 64'((i == 0) ? OPM_FIRST : OPM_ACC));
                else
                    checkOutput("opmode_seq_missing", 64'd0, 64'd1);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; cfg_kernel_len = '0; cfg_bias = '0;
        op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        curBias = '0; expLatency = 0; refCycle = 0; ceCount = 0;
        fork
            monitorLoop();
        join_none
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        checkOutput("reset_macc_rst", 64'(macc_rst), 64'd1);
        @(posedge CLK); #1;
        rst = 1'b0;
        @(negedge CLK);
        checkResetOutputs("reset");

        $display("[TB] directed N=3 continuous");
        jobA.delete(); jobB.delete();
        addPair(2, 3); addPair(4, 5); addPair(-1, 7);
        applyStimulus(3, CW'(10), 0, 0, 1'b0, 1'b0);

        $display("[TB] directed N=3 with bubble");
        applyStimulus(3, CW'(10), 2, 1, 1'b0, 1'b0);

        $display("[TB] directed N=1");
        jobA.delete(); jobB.delete();
        addPair(6, -2);
        applyStimulus(1, CW'(-5), 0, 0, 1'b0, 1'b0);

        $display("[TB] directed N=0");
        jobA.delete(); jobB.delete();
        applyStimulus(0, CW'(123), 0, 0, 1'b0, 1'b0);

        $display("[TB] result held with start pulses");
        addPair(-1234, 567); addPair(89, -10);
        applyStimulus(2, CW'(77), 0, 10, 1'b1, 1'b0);

        $display("[TB] reset during drain");
        jobA.delete(); jobB.delete();
        addPair(3, 4); addPair(5, 6); addPair(7, 8); addPair(9, 10);
        applyStimulus(4, CW'(1000), 0, 0, 1'b0, 1'b1);

        jobA.delete(); jobB.delete();
        addPair(1, 1); addPair(1, 1);
        applyStimulus(2, CW'(0), 0, 0, 1'b0, 1'b0);

        $display("[TB] wraparound");
        jobA.delete(); jobB.delete();
        addPair(-(1 << 29), -(1 << 17)); addPair(-(1 << 29), -(1 << 17)); addPair(-(1 << 29), -(1 << 17));
        applyStimulus(3, 48'h7FFF_FFFF_FFFF, 1, 0, 1'b0, 1'b0);

        $display("[TB] random jobs");
        for (int j = 0; j < 10; j++) begin
            jobA.delete(); jobB.delete();
            n = $urandom_range(0, 8);
            for (int i = 0; i < n; i++) begin
                jobA.push_back(AW'($urandom));
                jobB.push_back(BW'($urandom));
            end
            applyStimulus(n, CW'({$urandom, $urandom}), 1, $urandom_range(0, 3), 1'b0, 1'b0);
        end

        checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
